// File: rtl/mdiv_pkg.sv
// rtl/mdiv_pkg.sv - shared types and default sizes for the sequential multiply/divide unit
// Contents:
//   state_e          controller states (IDLE, MUL, DIV, DONE)
//   MDIV_WIDTH_DEF   default operand/result width
//   MDIV_TAGW_DEF    default destination-register tag width
package mdiv_pkg;

  localparam int MDIV_WIDTH_DEF = 32;
  localparam int MDIV_TAGW_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdiv_addsub.sv
// rtl/mdiv_addsub.sv - single adder used as add or subtract by both iteration datapaths
// Ports:
//   i_a    input  W  left operand
//   i_b    input  W  right operand
//   i_sub  input  1  1: i_a - i_b, 0: i_a + i_b
//   o_y    output W  sum / difference, modulo 2^W
module mdiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);

  logic [W-1:0] w_b_inv;
  logic [W-1:0] w_cin;

  // Subtraction as a + ~b + 1 keeps one carry chain for both modes.
  assign w_b_inv = i_b ^ {W{i_sub}};
  assign w_cin   = {{(W-1){1'b0}}, i_sub};
  assign o_y     = i_a + w_b_inv + w_cin;

endmodule

// File: rtl/mdiv_seq_unit.sv
// rtl/mdiv_seq_unit.sv - iterative signed multiply / divide unit with tag and cancel
// Ports:
//   clock           input  1      rising-edge clock
//   reset           input  1      synchronous active-high reset
//   ctrl_MULT       input  1      start signed multiply (idle only, wins over ctrl_DIV)
//   ctrl_DIV        input  1      start signed divide (idle only)
//   ctrl_cancel     input  1      flush: abort in-flight op / suppress completion
//   data_operandA   input  WIDTH  multiplicand / dividend
//   data_operandB   input  WIDTH  multiplier / divisor
//   tag_in          input  TAGW   destination tag captured at start
//   data_result     output WIDTH  product low half or quotient, held between completions
//   data_exception  output 1      overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY  output 1      one-cycle completion pulse
//   busy            output 1      operation in flight
//   tag_out         output TAGW   tag of the last completed operation
module mdiv_seq_unit
  import mdiv_pkg::*;
#(
  parameter int WIDTH = MDIV_WIDTH_DEF,
  parameter int TAGW  = MDIV_TAGW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_cancel,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAGW-1:0]  tag_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [TAGW-1:0]  tag_out
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  state_e             r_state;
  logic [CNTW-1:0]    r_cnt;
  // r_acc: upper product half (MUL) or partial remainder (DIV), one guard bit.
  logic [WIDTH:0]     r_acc;
  // r_q: multiplier shifting out (MUL) or dividend in / quotient out (DIV).
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg;
  logic               r_bzero;
  logic [TAGW-1:0]    r_tag;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic [TAGW-1:0]    r_tag_out;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_start;
  logic               w_last;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_as_a;
  logic [WIDTH:0]     w_as_b;
  logic               w_as_sub;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH:0]     w_prod_hi;
  logic               w_mul_exc;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_fin_res;
  logic               w_fin_exc;

  // The most-negative value negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign w_start = (ctrl_MULT || ctrl_DIV) && !ctrl_cancel;
  assign w_last  = (r_cnt == CNTW'(WIDTH));

  // Restoring division: shift next dividend bit into the remainder, then trial-subtract.
  assign w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};

  always_comb begin
    w_as_sub = 1'b0;
    w_as_a   = r_acc;
    w_as_b   = r_q[0] ? {1'b0, r_b} : '0;
    if (r_state == ST_DIV) begin
      w_as_sub = 1'b1;
      w_as_a   = w_div_shift;
      w_as_b   = {1'b0, r_b};
    end
  end

  mdiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .i_a   (w_as_a),
    .i_b   (w_as_b),
    .i_sub (w_as_sub),
    .o_y   (w_sum)
  );

  // Final-cycle sign application and overflow detection.
  assign w_prod    = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_prod_hi = w_prod_s[2*WIDTH-1:WIDTH-1];
  // Representable iff the upper half is a pure sign extension of bit WIDTH-1.
  assign w_mul_exc = !((&w_prod_hi) || !(|w_prod_hi));
  assign w_quo_s   = r_neg ? -r_q : r_q;

  always_comb begin
    w_fin_res = w_prod_s[WIDTH-1:0];
    w_fin_exc = w_mul_exc;
    if (r_state == ST_DIV) begin
      if (r_bzero) begin
        w_fin_res = '0;
        w_fin_exc = 1'b1;
      end else begin
        w_fin_res = w_quo_s;
        // Only most-negative / -1 yields a positive quotient with the top bit set.
        w_fin_exc = !r_neg && r_q[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_bzero   <= 1'b0;
      r_tag     <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_tag_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ctrl_MULT ? ST_MUL : ST_DIV;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_bzero <= (data_operandB == '0);
            r_tag   <= tag_in;
          end
        end
        ST_MUL, ST_DIV: begin
          if (ctrl_cancel) begin
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_result  <= w_fin_res;
            r_exc     <= w_fin_exc;
            r_tag_out <= r_tag;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
            if (r_state == ST_MUL) begin
              r_acc <= {1'b0, w_sum[WIDTH:1]};
              r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end else begin
              r_acc <= w_sum[WIDTH] ? w_div_shift : w_sum;
              r_q   <= {r_q[WIDTH-2:0], !w_sum[WIDTH]};
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = (r_state == ST_MUL) || (r_state == ST_DIV);
  // A flush during the DONE cycle still hides the completion from the pipeline.
  assign data_resultRDY = (r_state == ST_DONE) && !ctrl_cancel;
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign tag_out        = r_tag_out;

endmodule

// File: tb/tb_mdiv_seq_unit.sv
// tb/tb_mdiv_seq_unit.sv - directed self-checking bench for mdiv_seq_unit (WIDTH=32)
module tb_mdiv_seq_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        ctrl_cancel;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  tag_in;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [4:0]  tag_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mdiv_seq_unit #(.WIDTH(32), .TAGW(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_cancel    (ctrl_cancel),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .tag_in         (tag_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .tag_out        (tag_out)
  );

  // Starts one operation at "edge 0" and waits (bounded) for the completion pulse.
  // lat: edges from start to the RDY sample (-1 if never), bcnt: busy samples before RDY.
  task automatic do_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, output int lat, output int bcnt, output logic rdy_after);
    data_operandA = a;
    data_operandB = b;
    tag_in        = tg;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h12345678;
    tag_in        = 5'd31;
    bcnt = busy ? 1 : 0;
    lat  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    @(posedge clock); #1;
    rdy_after = data_resultRDY;
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b1; ctrl_DIV = 1'b0; ctrl_cancel = 1'b0;
    data_operandA = 32'd3; data_operandB = 32'd4; tag_in = 5'd9;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", data_result); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
    n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (tag_out !== 5'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", tag_out); end
    ctrl_MULT = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_mul_basic();
    int lat, bcnt; logic ra;
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 5'd3, lat, bcnt, ra);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    n_checks++; if (bcnt !== 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 33", bcnt); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL mul_rdy_one_cycle: got %b expected 0", ra); end
    n_checks++; if (data_result !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL mul_7x-6_result: got %h expected ffffffd6", data_result); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL mul_7x-6_exc: got %b expected 0", data_exception); end
    n_checks++; if (tag_out !== 5'd3) begin n_fail++; $display("FAIL mul_7x-6_tag: got %0d expected 3", tag_out); end
  endtask

  task automatic test_mul_overflow();
    int lat, bcnt; logic ra;
    logic [31:0] va [4] = '{32'h40000000, 32'h7FFFFFFF, 32'hFFFFFFFB, 32'h80000000};
    logic [31:0] vb [4] = '{32'd4,        32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF};
    logic [31:0] vr [4] = '{32'h0,        32'h80000001, 32'd25,       32'h80000000};
    logic        ve [4] = '{1'b1,         1'b0,         1'b0,         1'b1};
    for (int k = 0; k < 4; k++) begin
      do_op(1'b1, 1'b0, va[k], vb[k], 5'(k), lat, bcnt, ra);
      n_checks++; if (data_result !== vr[k]) begin n_fail++; $display("FAIL mul_vec%0d_result: got %h expected %h", k, data_result, vr[k]); end
      n_checks++; if (data_exception !== ve[k]) begin n_fail++; $display("FAIL mul_vec%0d_exc: got %b expected %b", k, data_exception, ve[k]); end
    end
  endtask

  task automatic test_div();
    int lat, bcnt; logic ra;
    logic [31:0] va [5] = '{32'hFFFFFFF9, 32'd100, 32'd7,        32'hFFFFFF9C, 32'd5};
    logic [31:0] vb [5] = '{32'd2,        32'd7,   32'hFFFFFFFE, 32'hFFFFFFF9, 32'd0};
    logic [31:0] vr [5] = '{32'hFFFFFFFD, 32'd14,  32'hFFFFFFFD, 32'd14,       32'd0};
    logic        ve [5] = '{1'b0,         1'b0,    1'b0,         1'b0,         1'b1};
    for (int k = 0; k < 5; k++) begin
      do_op(1'b0, 1'b1, va[k], vb[k], 5'(k + 8), lat, bcnt, ra);
      n_checks++; if (data_result !== vr[k]) begin n_fail++; $display("FAIL div_vec%0d_result: got %h expected %h", k, data_result, vr[k]); end
      n_checks++; if (data_exception !== ve[k]) begin n_fail++; $display("FAIL div_vec%0d_exc: got %b expected %b", k, data_exception, ve[k]); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_vec%0d_latency: got %0d expected 33", k, lat); end
    end
  endtask

  task automatic test_div_overflow();
    int lat, bcnt; logic ra;
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd12, lat, bcnt, ra);
    n_checks++; if (data_result !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_result: got %h expected 80000000", data_result); end
    n_checks++; if (data_exception !== 1'b1) begin n_fail++; $display("FAIL div_ovf_exc: got %b expected 1", data_exception); end
    n_checks++; if (tag_out !== 5'd12) begin n_fail++; $display("FAIL div_ovf_tag: got %0d expected 12", tag_out); end
  endtask

  task automatic test_both_start();
    int lat, bcnt; logic ra;
    do_op(1'b1, 1'b1, 32'd6, 32'd7, 5'd7, lat, bcnt, ra);
    n_checks++; if (data_result !== 32'd42) begin n_fail++; $display("FAIL both_start_result: got %h expected 0000002a", data_result); end
  endtask

  task automatic test_cancel();
    int rdy_seen = 0;
    int busy_seen = 0;
    data_operandA = 32'd2; data_operandB = 32'd2; tag_in = 5'd20;
    ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    ctrl_DIV = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_before: got %b expected 1", busy); end
    ctrl_DIV = 1'b0;
    ctrl_cancel = 1'b1;
    @(posedge clock); #1;
    ctrl_cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_after: got %b expected 0", busy); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_seen++;
      if (busy) busy_seen++;
    end
    n_checks++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL cancel_no_rdy: got %0d pulses expected 0", rdy_seen); end
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL cancel_no_queue: got %0d busy cycles expected 0", busy_seen); end
    n_checks++; if (data_result !== 32'd42) begin n_fail++; $display("FAIL cancel_result_held: got %h expected 0000002a", data_result); end
    n_checks++; if (tag_out !== 5'd7) begin n_fail++; $display("FAIL cancel_tag_held: got %0d expected 7", tag_out); end
    // Start and cancel in the same idle cycle: the start must be dropped.
    ctrl_MULT = 1'b1; ctrl_cancel = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_start: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; logic ra;
    data_operandA = 32'd100; data_operandB = 32'd7; tag_in = 5'd4;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    ctrl_cancel = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    ctrl_cancel = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: got %b expected 0", data_resultRDY); end
    n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 00000000", data_result); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL rstmid_exc: got %b expected 0", data_exception); end
    n_checks++; if (tag_out !== 5'd0) begin n_fail++; $display("FAIL rstmid_tag: got %0d expected 0", tag_out); end
    do_op(1'b1, 1'b0, 32'd3, 32'd3, 5'd2, lat, bcnt, ra);
    n_checks++; if (data_result !== 32'd9) begin n_fail++; $display("FAIL rstmid_mul3x3_result: got %h expected 00000009", data_result); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rstmid_mul3x3_latency: got %0d expected 33", lat); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_overflow();
    test_div();
    test_div_overflow();
    test_both_start();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
